pc_sequencer: RTL

- Parametrised successor to the combinational next-PC computation: owns the architectural PC register, not just the next-PC arithmetic.
- Computes the next PC for sequential, unconditional, CBZ/CBNZ, BL, BR and RET flows, supports pipeline stall, and contains a circular return-address stack (RAS).
- The RAS predicts RET targets; saturating counters record RAS prediction accuracy.
- Sits between instruction fetch and the branch/ALU decision logic; CurrentPC drives the instruction-memory address.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_sequencer_ras.sv | 56 +++++
 rtl/pc_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the PC sequencer.
//   branch_t      3-bit branch-type code carried on BranchType
//   BR_SEQ..BR_RET, BR_RSVD  branch-type encodings (reserved behaves as SEQ)
//   INSTR_BYTES   instruction size in bytes (sequential PC increment)
package pc_seq_pkg;

  typedef logic [2:0] branch_t;

  localparam branch_t BR_SEQ  = 3'd0;
  localparam branch_t BR_B    = 3'd1;
  localparam branch_t BR_CBZ  = 3'd2;
  localparam branch_t BR_CBNZ = 3'd3;
  localparam branch_t BR_BL   = 3'd4;
  localparam branch_t BR_BR   = 3'd5;
  localparam branch_t BR_RET  = 3'd6;
  localparam branch_t BR_RSVD = 3'd7;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_sequencer_ras.sv
// ras_stack: circular return-address stack.
//   i_clk     clock, rising edge
//   i_resetl  synchronous active-low reset (clears pointer and count only)
//   i_push    write i_data at the pointer and advance; overwrites oldest when full
//   i_pop     retreat the pointer; ignored when empty
//   i_data    return address to push
//   o_top     most recently pushed valid entry, 0 when empty
//   o_count   number of valid entries (0..DEPTH)
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                       i_clk,
  input  logic                       i_resetl,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_top,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_top_idx;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign w_top_idx = r_ptr - PTR_ONE;

  always_ff @(posedge i_clk) begin
    if (!i_resetl) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_ONE;
      if (r_count != CNT_FULL) r_count <= r_count + CNT_ONE;
    end else if (i_pop && (r_count != '0)) begin
      r_ptr   <= r_ptr - PTR_ONE;
      r_count <= r_count - CNT_ONE;
    end
  end

  // Entry contents need no reset; validity is tracked by r_count.
  always_ff @(posedge i_clk) begin
    if (i_resetl && i_push) r_mem[r_ptr] <= i_data;
  end

  assign o_top   = (r_count != '0) ? r_mem[w_top_idx] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC register, next-PC selection and RET prediction.
//   CLK          clock, rising edge
//   resetl       synchronous active-low reset; loads startPC, clears RAS/counters
//   startPC      PC loaded at reset
//   Stall        hold PC, RAS and counters this cycle
//   BranchType   SEQ/B/CBZ/CBNZ/BL/BR/RET (7 reserved = SEQ)
//   ALUZero      condition for CBZ/CBNZ
//   SignExtImm   sign-extended word offset
//   RegTarget    register target for BR/RET
//   CurrentPC    registered PC (instruction-memory address)
//   NextPC       combinational next PC
//   RasPredPC    RAS top entry, 0 when empty
//   RasHit       RET whose RAS prediction matches RegTarget
//   RasCount     valid RAS entries
//   RetCount     RETs retired (saturating)
//   RetHitCount  RETs retired with RasHit (saturating)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         CLK,
  input  logic                         resetl,
  input  logic [ADDR_W-1:0]            startPC,
  input  logic                         Stall,
  input  logic [2:0]                   BranchType,
  input  logic                         ALUZero,
  input  logic [ADDR_W-1:0]            SignExtImm,
  input  logic [ADDR_W-1:0]            RegTarget,
  output logic [ADDR_W-1:0]            CurrentPC,
  output logic [ADDR_W-1:0]            NextPC,
  output logic [ADDR_W-1:0]            RasPredPC,
  output logic                         RasHit,
  output logic [$clog2(RAS_DEPTH):0]   RasCount,
  output logic [CNT_W-1:0]             RetCount,
  output logic [CNT_W-1:0]             RetHitCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_next;
  logic [CNT_W-1:0]  r_ret_cnt;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic              w_is_bl;
  logic              w_is_ret;
  logic              w_hit;
  logic [ADDR_W-1:0] w_ras_top;
  logic [$clog2(RAS_DEPTH):0] w_ras_cnt;
  branch_t           w_bt;

  assign w_bt     = branch_t'(BranchType);
  assign w_seq    = r_pc + ADDR_W'(INSTR_BYTES);
  assign w_tgt    = r_pc + (SignExtImm << 2);
  assign w_is_bl  = (w_bt == BR_BL);
  assign w_is_ret = (w_bt == BR_RET);

  always_comb begin
    w_next = w_seq;
    case (w_bt)
      BR_B, BR_BL:   w_next = w_tgt;
      BR_CBZ:        w_next = ALUZero ? w_tgt : w_seq;
      BR_CBNZ:       w_next = ALUZero ? w_seq : w_tgt;
      BR_BR, BR_RET: w_next = RegTarget;
      default:       w_next = w_seq;
    endcase
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .i_clk    (CLK),
    .i_resetl (resetl),
    .i_push   (w_is_bl && !Stall),
    .i_pop    (w_is_ret && !Stall),
    .i_data   (w_seq),
    .o_top    (w_ras_top),
    .o_count  (w_ras_cnt)
  );

  assign w_hit = w_is_ret && (w_ras_cnt != '0) && (w_ras_top == RegTarget);

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      r_pc      <= startPC;
      r_ret_cnt <= '0;
      r_hit_cnt <= '0;
    end else if (!Stall) begin
      r_pc <= w_next;
      if (w_is_ret) begin
        if (r_ret_cnt != '1) r_ret_cnt <= r_ret_cnt + CNT_ONE;
        if (w_hit && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + CNT_ONE;
      end
    end
  end

  assign CurrentPC   = r_pc;
  assign NextPC      = w_next;
  assign RasPredPC   = w_ras_top;
  assign RasHit      = w_hit;
  assign RasCount    = w_ras_cnt;
  assign RetCount    = r_ret_cnt;
  assign RetHitCount = r_hit_cnt;

endmodule
